// File: rtl/mux_n_rr_if.sv
// Bus bundle for mux_n_rr: channel inputs, mode/select control, and the
// valid/ready output stage. The slave modport is the mux; the master
// modport is whatever drives the sources and consumes the output word.
interface mux_n_rr_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       req;
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic                      enable;
    logic                      ready;
    logic [WIDTH-1:0]          mux_out;
    logic                      valid;
    logic [SEL_W-1:0]          chan_out;
    logic [CHANNELS-1:0]       grant;

    modport master (
        output data_in, req, mode, select, enable, ready,
        input  mux_out, valid, chan_out, grant
    );

    modport slave (
        input  data_in, req, mode, select, enable, ready,
        output mux_out, valid, chan_out, grant
    );
endinterface

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with external-select or round-robin
// arbitration and a valid/ready output register.
// Optional feature macro: MUX_TRISTATE_EN (mux_out floats while enable=0).
module mux_n_rr #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input logic        clock,
    input logic        reset,
    mux_n_rr_if.slave  bus
);
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             valid_q;
    logic [SEL_W-1:0] ptr_q;

    logic             free;
    logic             cand_found;
    logic [SEL_W-1:0] cand;
    logic             capture;

    // Candidate selection: external select, or first requester after ptr
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        if (!bus.mode) begin
            if (bus.req[bus.select]) begin
                cand_found = 1'b1;
                cand       = bus.select;
            end
        end else begin
            // Walk from farthest (ptr itself) to nearest so ptr+1 wins last
            for (int i = CHANNELS; i >= 1; i--) begin
                if (bus.req[SEL_W'(ptr_q + SEL_W'(i))]) begin
                    cand_found = 1'b1;
                    cand       = SEL_W'(ptr_q + SEL_W'(i));
                end
            end
        end
    end

    assign free    = !valid_q || bus.ready;
    assign capture = bus.enable && free && cand_found;

    // Grant is forced low while reset is held so sources never see a consume
    assign bus.grant = (capture && reset) ? (CHANNELS'(1) << cand) : '0;

    // Output register and round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SEL_W'(CHANNELS - 1);
        end else if (capture) begin
            data_q  <= bus.data_in[cand*WIDTH +: WIDTH];
            chan_q  <= cand;
            valid_q <= 1'b1;
            ptr_q   <= cand;
        end else if (bus.ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef MUX_TRISTATE_EN
    assign bus.mux_out = bus.enable ? data_q : {WIDTH{1'bz}};
`else
    assign bus.mux_out = data_q;
`endif
    assign bus.valid    = valid_q;
    assign bus.chan_out = chan_q;
endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, W-bit registered multiplexer: the next generation of our 4-to-1 32-bit enable mux. It adds a flattened multi-channel input bus, per-channel request lines, a round-robin mode alongside external select, and a valid/ready output stage. It sits between several word sources and a single downstream consumer, such as a shared bus or datapath port. The output register holds its word until the consumer accepts it.

## Interface
- WIDTH, 32, data word width (≥1)
- CHANNELS, 4, number of input channels (power of 2, ≥2)
- SEL_W, 2, select/index width; must equal log2(CHANNELS)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- req  in  CHANNELS  req[k]=1: channel k has a word available
- mode  in  1  0 = external select, 1 = round-robin
- select  in  SEL_W  channel index used when mode=0
- enable  in  1  permits capture; also gates the output drive (see Configuration)
- ready  in  1  downstream accepts the held word this cycle
- mux_out  out  WIDTH  registered data word
- valid  out  1  mux_out holds a word not yet accepted
- chan_out  out  SEL_W  channel index of the held word
- grant  out  CHANNELS  combinational one-hot; grant[k]=1 in the cycle channel k is captured

## Operation
- Internal state: output register (mux_out, chan_out, valid) and round-robin pointer ptr (last captured channel).
- Slot free: free = !valid || ready.
- Candidate, mode=0: c = select, but only if req[select]=1; otherwise there is no candidate.
- Candidate, mode=1: the first k with req[k]=1, searching ptr+1, ptr+2, … cyclically modulo CHANNELS; ptr itself is checked last.
- Capture when enable && free && a candidate exists:
  - mux_out <= data_in slice c
  - chan_out <= c
  - valid <= 1
  - ptr <= c (in either mode)
  - grant[c] = 1 in that cycle
- Otherwise, if ready, valid <= 0. mux_out and chan_out keep their last value.
- grant is all zeros in every cycle with no capture. Sources must treat grant[k] as "word consumed" and may change data_in or req at the next edge.
- enable=0 blocks capture only. A held valid word still drains when ready=1.
- A mode or select change takes effect in the same cycle's candidate evaluation. No state is flushed.
- When ready=1 and a capture both occur in one cycle, the new word replaces the accepted one; valid stays 1.
- Reset (asynchronous, any time including mid-transfer):
  - mux_out=0, chan_out=0, valid=0
  - ptr=CHANNELS-1, so channel 0 has first priority
  - grant=0 while reset is asserted
  - A word held at reset is discarded.

## Timing
- Latency is 1 clock from capture (grant high) to valid/mux_out.
- Throughput is one word per clock while ready=1 and a candidate exists.
- Backpressure: with valid=1 and ready=0, mux_out, chan_out and valid are stable and grant=0.
- grant depends combinationally on req, mode, select, enable, valid, ready and ptr. There is no path from data_in to grant.
- Reset release: the first capture can occur at the first rising edge after reset deasserts.

## Configuration
- MUX_TRISTATE_EN
  - Defined: mux_out = enable ? register : {WIDTH{1'bz}}. The output drive is combinational; register contents are unaffected, and valid and chan_out are always driven.
  - Not defined: mux_out is always the register value. enable only gates capture.

## Test plan
- Reset/idle: assert reset mid-transfer with valid=1 → mux_out=0, valid=0, chan_out=0, grant=0 immediately. Release with req=4'b0000 → no capture.
- Select mode: CHANNELS=4, WIDTH=32, mode=0, select=2, req=4'b0100, data ch2=32'hA5A5_0002, ready=1 → grant=4'b0100. Next cycle mux_out=32'hA5A5_0002, chan_out=2, valid=1. With select=1 and req[1]=0 → no capture.
- Round-robin fairness: mode=1, req=4'b1111, ready=1 continuously → captured channels 0,1,2,3,0,… Then req=4'b1010 with ptr=1 → next 3, then 1.
- Backpressure: valid=1, ready=0 for 3 cycles with req=4'b1111 → grant=0 and mux_out stable. On the ready=1 cycle, simultaneous capture keeps valid=1 with the new word.
- Enable: enable=0 with valid=1 and ready=1 → valid drops next cycle, no grant. With MUX_TRISTATE_EN defined, mux_out=32'hzzzz_zzzz while enable=0. Without it, mux_out holds the last word.
